// File: rtl/dpi_seq_pkg.sv
// Shared definitions for the DPI stream sequencer.
// Contents: stream slot width, flow table depth and FSM state encodings.
package dpi_seq_pkg;

  localparam int unsigned STREAM_W  = 6;
  localparam int unsigned NUM_SLOTS = 64;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLookup = 3'd1;
  localparam state_t StLoad   = 3'd2;
  localparam state_t StWait   = 3'd3;
  localparam state_t StStream = 3'd4;
  localparam state_t StGap    = 3'd5;
  localparam state_t StEop    = 3'd6;

endpackage

// File: rtl/dpi_flow_table.sv
// Flow table: maps a flow key to a stream slot. Holds the key CAM, valid bits,
// per-slot regex-enable masks and the round-robin eviction pointer.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   lookup, key         lookup request (one cycle) and key to look up
//   hit, slot           key found / resolved slot (hit, lowest free, or victim)
//   evict               miss with full table; slot is the victim
//   mask                enable mask that the resolved slot will carry
//   cfg_we/slot/mask    mask write port
module dpi_flow_table
  import dpi_seq_pkg::*;
#(
  parameter int unsigned           KEY_W        = 32,
  parameter int unsigned           NUM_REGEX    = 8,
  parameter logic [NUM_REGEX-1:0]  DEFAULT_MASK = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup,
  input  logic [KEY_W-1:0]     key,
  output logic                 hit,
  output logic [STREAM_W-1:0]  slot,
  output logic                 evict,
  output logic [NUM_REGEX-1:0] mask,
  input  logic                 cfg_we,
  input  logic [STREAM_W-1:0]  cfg_slot,
  input  logic [NUM_REGEX-1:0] cfg_mask
);

  logic [KEY_W-1:0]     keys_q  [NUM_SLOTS];
  logic [NUM_REGEX-1:0] masks_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  logic [STREAM_W-1:0]  ptr_q;
  logic [STREAM_W-1:0]  hit_idx;
  logic [STREAM_W-1:0]  free_idx;
  logic                 free_found;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && (keys_q[i] == key)) begin
        hit     = 1'b1;
        hit_idx = STREAM_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = STREAM_W'(i);
      end
    end
  end

  assign slot  = hit ? hit_idx : (free_found ? free_idx : ptr_q);
  assign evict = !hit && !free_found;

  // A cfg write landing on the resolved slot in the lookup cycle wins.
  assign mask = (cfg_we && (cfg_slot == slot)) ? cfg_mask :
                (hit ? masks_q[slot] : DEFAULT_MASK);

  // Keys need no reset: valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (lookup && !hit) begin
      keys_q[slot] <= key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        masks_q[i] <= DEFAULT_MASK;
      end
    end else begin
      if (lookup && !hit) begin
        valid_q[slot] <= 1'b1;
        masks_q[slot] <= DEFAULT_MASK;
        if (evict) begin
          ptr_q <= ptr_q + 1'b1;
        end
      end
      // Last assignment: cfg overrides a same-cycle allocation.
      if (cfg_we) begin
        masks_q[cfg_slot] <= cfg_mask;
      end
    end
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// DPI stream sequencer: maps each packet's flow key to a stream slot and drives
// the load_state / char / eop sequence plus per-slot enable mask to the matchers.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/ready/data/sop/eop    packet byte stream; in_key valid with sop
//   cfg_we/slot/mask               per-slot enable mask write
//   char_in, char_in_vld           byte to matchers (1-cycle registered)
//   load_state, new_stream_id      restore-state pulse and fresh-slot qualifier
//   stream_id, enable              current slot and mask, held load_state..eop
//   eop, busy                      end-of-packet pulse, FSM not idle
// Optional: define DPI_SEQ_STATS_EN to add saturating stat_hits, stat_misses,
// stat_evicts outputs (one increment per lookup, by outcome).
module dpi_stream_sequencer
  import dpi_seq_pkg::*;
#(
  parameter int unsigned          KEY_W        = 32,
  parameter int unsigned          NUM_REGEX    = 8,
  parameter int unsigned          EOP_GAP      = 2,
  parameter logic [NUM_REGEX-1:0] DEFAULT_MASK = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [KEY_W-1:0]     in_key,
  input  logic                 cfg_we,
  input  logic [5:0]           cfg_slot,
  input  logic [NUM_REGEX-1:0] cfg_mask,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 load_state,
  output logic                 new_stream_id,
  output logic [5:0]           stream_id,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy
`ifdef DPI_SEQ_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [31:0]          stat_evicts
`endif
);

  state_t                state_q;
  logic [KEY_W-1:0]      key_q;
  logic [STREAM_W-1:0]   sid_q;
  logic                  new_q;
  logic [NUM_REGEX-1:0]  en_q;
  logic [7:0]            char_q;
  logic                  vld_q;
  logic [7:0]            gap_cnt_q;

  logic                  lookup;
  logic                  accept;
  logic                  tbl_hit;
  logic                  tbl_evict;
  logic [STREAM_W-1:0]   tbl_slot;
  logic [NUM_REGEX-1:0]  tbl_mask;

  assign lookup = (state_q == StLookup);
  // In IDLE a non-sop beat is dropped; the sop beat is held until STREAM.
  assign in_ready = (state_q == StStream) ||
                    ((state_q == StIdle) && in_valid && !in_sop);
  assign accept   = in_valid && in_ready;

  dpi_flow_table #(
    .KEY_W        (KEY_W),
    .NUM_REGEX    (NUM_REGEX),
    .DEFAULT_MASK (DEFAULT_MASK)
  ) u_flow_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .lookup   (lookup),
    .key      (key_q),
    .hit      (tbl_hit),
    .slot     (tbl_slot),
    .evict    (tbl_evict),
    .mask     (tbl_mask),
    .cfg_we   (cfg_we),
    .cfg_slot (cfg_slot),
    .cfg_mask (cfg_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      key_q     <= '0;
      sid_q     <= '0;
      new_q     <= 1'b0;
      en_q      <= '0;
      char_q    <= '0;
      vld_q     <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid && in_sop) begin
            key_q   <= in_key;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          sid_q   <= tbl_slot;
          new_q   <= !tbl_hit;
          en_q    <= tbl_mask;
          state_q <= StLoad;
        end
        StLoad:   state_q <= StWait;
        StWait:   state_q <= StStream;
        StStream: begin
          if (accept) begin
            char_q <= in_data;
            vld_q  <= 1'b1;
            if (in_eop) begin
              gap_cnt_q <= '0;
              state_q   <= StGap;
            end
          end
        end
        StGap: begin
          // First GAP cycle still carries the last char; then EOP_GAP idle cycles.
          if (gap_cnt_q == 8'(EOP_GAP)) begin
            state_q <= StEop;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        StEop:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign char_in       = char_q;
  assign char_in_vld   = vld_q;
  assign load_state    = (state_q == StLoad);
  assign new_stream_id = load_state && new_q;
  assign stream_id     = sid_q;
  assign enable        = en_q;
  assign eop           = (state_q == StEop);
  assign busy          = (state_q != StIdle);

`ifdef DPI_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (lookup) begin
      if (tbl_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else if (tbl_evict) begin
        if (stat_evicts != '1) stat_evicts <= stat_evicts + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = tbl_evict;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Self-checking bench for dpi_stream_sequencer: directed packets with
// hand-computed slot / new / mask / timing expectations.
module tb_dpi_stream_sequencer;

  localparam int EOP_GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [7:0]  in_data;
  logic [31:0] in_key;
  logic        cfg_we;
  logic [5:0]  cfg_slot;
  logic [7:0]  cfg_mask;
  logic [7:0]  char_in;
  logic        char_in_vld, load_state, new_stream_id, eop, busy;
  logic [5:0]  stream_id;
  logic [7:0]  enable;

  always #5 clk = ~clk;

  dpi_stream_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_key        (in_key),
    .cfg_we        (cfg_we),
    .cfg_slot      (cfg_slot),
    .cfg_mask      (cfg_mask),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .eop           (eop),
    .enable        (enable),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: records per-packet events at the negedge.
  int         cyc = 0, load_cyc = 0, first_char_cyc = 0, last_char_cyc = 0, eop_cyc = 0;
  int         eop_cnt = 0, load_cnt = 0;
  logic [5:0] ld_sid;
  logic       ld_new;
  logic [7:0] ld_en;
  bit         in_pkt = 0, got_first = 0, unstable = 0;
  logic [7:0] chars[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) in_pkt = 0;
    if (load_state) begin
      load_cyc  = cyc;
      ld_sid    = stream_id;
      ld_new    = new_stream_id;
      ld_en     = enable;
      in_pkt    = 1;
      got_first = 0;
      unstable  = 0;
      load_cnt++;
      chars.delete();
    end
    if (char_in_vld) begin
      chars.push_back(char_in);
      if (!got_first) begin
        first_char_cyc = cyc;
        got_first      = 1;
      end
      last_char_cyc = cyc;
    end
    if (in_pkt && ((stream_id !== ld_sid) || (enable !== ld_en))) unstable = 1;
    if (eop) begin
      eop_cyc = cyc;
      eop_cnt++;
      in_pkt = 0;
    end
  end

  task automatic drive_pkt(input logic [31:0] key, input int n, input logic [7:0] base,
                           input bit gaps);
    int i = 0;
    int guard = 0;
    bit acc;
    @(negedge clk);
    while (i < n && guard < 200) begin
      guard++;
      in_key   = key;
      in_sop   = (i == 0);
      in_eop   = (i == n - 1);
      in_data  = base + 8'(i);
      in_valid = !(gaps && (guard % 2 == 1));
      #1 acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) i++;
    end
    in_valid = 0;
    in_sop   = 0;
    in_eop   = 0;
    if (guard >= 200) chk("drive_timeout", 1, 0);
  endtask

  task automatic cfg_pulse(input int dly, input logic [5:0] slot, input logic [7:0] m);
    repeat (dly) @(negedge clk);
    cfg_slot = slot;
    cfg_mask = m;
    cfg_we   = 1;
    @(negedge clk);
    cfg_we   = 0;
  endtask

  task automatic run_pkt(input string tag, input logic [31:0] key, input int n,
                         input logic [7:0] base, input bit gaps, input logic [5:0] exp_sid,
                         input logic exp_new, input logic [7:0] exp_en, input int cfg_dly,
                         input logic [7:0] cfg_m);
    int e0 = eop_cnt;
    int l0 = load_cnt;
    int w = 0;
    int nbad = 0;
    if (cfg_dly > 0) begin
      fork
        drive_pkt(key, n, base, gaps);
        cfg_pulse(cfg_dly, exp_sid, cfg_m);
      join
    end else begin
      drive_pkt(key, n, base, gaps);
    end
    #1;
    while (eop_cnt == e0 && w < 80) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk({tag, "_eop"}, 64'(eop_cnt - e0), 1);
    chk({tag, "_load"}, 64'(load_cnt - l0), 1);
    chk({tag, "_sid"}, 64'(ld_sid), 64'(exp_sid));
    chk({tag, "_new"}, 64'(ld_new), 64'(exp_new));
    chk({tag, "_en"}, 64'(ld_en), 64'(exp_en));
    chk({tag, "_nchar"}, 64'(chars.size()), 64'(n));
    for (int i = 0; i < chars.size(); i++) if (chars[i] !== base + 8'(i)) nbad++;
    chk({tag, "_data"}, 64'(nbad), 0);
    if (gaps) chk({tag, "_wait"}, 64'(first_char_cyc - load_cyc >= 3), 1);
    else      chk({tag, "_wait"}, 64'(first_char_cyc - load_cyc), 3);
    chk({tag, "_gap"}, 64'(eop_cyc - last_char_cyc), 64'(EOP_GAP + 1));
    chk({tag, "_stable"}, 64'(unstable), 0);
  endtask

  initial begin
    int e0;
    int w;
    rst_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0; in_key = 0;
    cfg_we = 0; cfg_slot = 0; cfg_mask = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_load", load_state, 0);
    chk("rst_new", new_stream_id, 0);
    chk("rst_eop", eop, 0);
    chk("rst_vld", char_in_vld, 0);
    chk("rst_sid", stream_id, 0);
    chk("rst_en", enable, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1;

    run_pkt("p1", 32'hA5A5A5A5, 3, 8'h10, 0, 6'd0, 1, 8'hFF, 0, 8'h00);
    run_pkt("p2", 32'hA5A5A5A5, 3, 8'h20, 0, 6'd0, 0, 8'hFF, 0, 8'h00);
    run_pkt("p3", 32'h12345678, 2, 8'h30, 0, 6'd1, 1, 8'hFF, 0, 8'h00);
    cfg_pulse(1, 6'd0, 8'h05);
    run_pkt("p4", 32'hA5A5A5A5, 3, 8'h40, 0, 6'd0, 0, 8'h05, 5, 8'h3C);
    run_pkt("p5", 32'hA5A5A5A5, 2, 8'h50, 0, 6'd0, 0, 8'h3C, 0, 8'h00);
    run_pkt("p6", 32'h12345678, 4, 8'h60, 1, 6'd1, 0, 8'hFF, 0, 8'h00);
    run_pkt("p7", 32'hCAFEF00D, 1, 8'h70, 0, 6'd2, 1, 8'hFF, 0, 8'h00);

    // Reset pulse in the middle of a stream.
    e0 = eop_cnt;
    fork
      drive_pkt(32'hDEADBEEF, 6, 8'h80, 0);
      begin
        w = 0;
        @(negedge clk);
        #1;
        while (!char_in_vld && w < 40) begin
          @(negedge clk);
          #1;
          w++;
        end
        chk("mid_reached_stream", char_in_vld, 1);
        chk("mid_sid_before", stream_id, 6'd3);
        #1 rst_n = 0;
        #1;
        chk("mid_vld", char_in_vld, 0);
        chk("mid_busy", busy, 0);
        chk("mid_sid", stream_id, 0);
        chk("mid_en", enable, 0);
        chk("mid_load", load_state, 0);
        chk("mid_eop", eop, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
      end
    join
    repeat (10) @(negedge clk);
    chk("mid_no_eop", 64'(eop_cnt - e0), 0);

    run_pkt("p9", 32'hA5A5A5A5, 2, 8'h90, 0, 6'd0, 1, 8'hFF, 0, 8'h00);
    for (int k = 1; k < 64; k++) begin
      run_pkt($sformatf("fill%0d", k), 32'h10000000 + 32'(k), 1, 8'(k), 0, 6'(k), 1,
              8'hFF, 0, 8'h00);
    end
    run_pkt("evict0", 32'h20000000, 1, 8'hA0, 0, 6'd0, 1, 8'hFF, 0, 8'h00);
    run_pkt("evict1", 32'hA5A5A5A5, 1, 8'hB0, 0, 6'd1, 1, 8'hFF, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
